alu_job_arbiter: RTL and testbench
==================================

// Module: alu_job_arbiter
// PURPOSE
//  Shares one ALU datapath between NREQ requesters. Requesters present 20-bit jobs {A[7:0],B[7:0],op[3:0]}.
//  A round-robin arbiter picks one job per cycle and registers it, then a combinational alu_core evaluates it.
//  The result is queued with a requester tag and a core tag (op[3:2]), and returned over a valid/ready interface.
//  Sits between job sources and result consumers in the multicore ALU subsystem.
// PARAMETERS
//  NREQ        4   number of requesters; must be >= 2
//  FIFO_DEPTH  4   result queue entries; must be a power of 2 and >= 2
// PORTS
//  clk         in   1          clock, all state on rising edge
//  rst         in   1          asynchronous reset, active-high
//  req_valid   in   NREQ       job valid, one bit per requester
//  req_opcode  in   20*NREQ    requester i job at [20*i+19:20*i]: {A,B,op}
//  req_ready   out  NREQ       one-hot grant; a job is accepted when req_valid[i] & req_ready[i]
//  res_valid   out  1          result available at queue head
//  res_data    out  16         ALU result
//  res_id      out  $clog2(NREQ)  requester index of the result
//  res_core    out  2          core flag = op[3:2] of the job
//  res_ready   in   1          consumer accepts the result when res_valid & res_ready
//  busy        out  1          s1_valid | (count != 0)
// BEHAVIOUR
//  Reset: clears rr_ptr, s1_valid, FIFO pointers and count.
//   res_valid=0, res_data/res_id/res_core=0, busy=0, req_ready=0.
//   Reset mid-operation discards the in-flight job and all queued results.
//  Credit: space = (FIFO_DEPTH - count - s1_valid) > 0.
//   A pop in the same cycle does NOT create space; the check is conservative.
//  Arbitration: if space, grant the first i with req_valid[i], searching from rr_ptr upward with wrap.
//   req_ready = one-hot grant, combinational from req_valid; all zero when space == 0.
//  rr_ptr <= (granted_i + 1) mod NREQ on accept; otherwise unchanged.
//  Stage 1: on accept, s1_valid<=1, s1_job<=opcode, s1_id<=i; otherwise s1_valid<=0.
//  Stage 2: when s1_valid, push {s1_id, s1_job[3:2], alu_core(s1_job)} into the FIFO.
//   Push is never blocked because the credit was reserved at accept.
//  ALU, by op[1:0]:
//   00: A+B zero-extended to 16 bits (max 510)
//   01: A-B in 16-bit two's complement, wraps (3-5 = 16'hFFFE)
//   10: A*B, 16-bit unsigned
//   11: 16'h0000
//  Latency: job accepted at edge N; pushed at edge N+1; res_valid=1 after edge N+1 if the queue was empty.
//  Sustained throughput is 1 job/cycle when res_ready=1 and FIFO_DEPTH >= 3.
//  res_valid = (count != 0). res_* show the head entry, and are forced to 0 when the queue is empty.
//  Pop on res_valid & res_ready. Simultaneous push and pop leaves count unchanged; pointers wrap mod FIFO_DEPTH.
//  Results return in acceptance order; no reordering between requesters.
//  A request held with req_valid and no grant stays pending. Its opcode must stay stable until accepted.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined: adds output ports
//   stat_jobs  out 32: count of accepted jobs, saturates at 32'hFFFF_FFFF
//   stat_stall out 32: count of cycles with |req_valid and no grant, saturates
//   Both counters reset to 0.
//  ALU_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package alu_pkg holds:
//   JOB_W=20, RES_W=16
//   op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_NOP=2'b11
//   a result-entry struct {id, core[1:0], data[15:0]}
//  One sub-module: alu_core, a combinational {A,B,op} -> 16-bit result per the table above.
//  Arbiter, stage-1 register and FIFO stay in this module.
// TESTING
//  T1 reset: 3 jobs queued, pulse rst -> res_valid=0, busy=0 immediately; no stale result after release.
//  T2 single job: req 2, {8'd200,8'd100,4'b0010}
//     -> 2 edges later res_valid=1, res_data=16'd20000, res_id=2, res_core=0.
//  T3 arithmetic: {3,5,4'b0101} -> 16'hFFFE, core 1; {255,255,4'b1000} -> 16'd510, core 2;
//     {9,9,4'b1111} -> 16'h0000, core 3.
//  T4 round robin: all req_valid=1, res_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; res_id in the same order.
//  T5 backpressure: res_ready=0, all valid -> exactly FIFO_DEPTH accepts, then req_ready=0.
//     Raise res_ready -> in-order drain, accepts resume.
//  T6 with ALU_ARB_STATS_EN: after T5, stat_jobs = accepted count and stat_stall = stalled cycles;
//     both read 0 after rst.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared widths, ALU op encodings and result-queue entry type
//               for the multicore ALU subsystem.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int JOB_W = 20;
  localparam int RES_W = 16;

  // Maximum requester-index width carried in a queue entry (up to 256 requesters)
  localparam int ID_MAX_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [1:0]          core;
    logic [RES_W-1:0]    data;
  } res_entry_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational 8-bit ALU, job {A[7:0],B[7:0],op[3:0]} -> 16-bit
//               result selected by op[1:0]. op[3:2] is a routing tag only.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
(
  input  logic [JOB_W-1:0] job,
  output logic [RES_W-1:0] result
);

  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [1:0] w_op;
  logic       w_unused_tag;

  assign w_a          = job[19:12];
  assign w_b          = job[11:4];
  assign w_op         = job[1:0];
  // The core tag travels alongside the result, it never affects arithmetic
  assign w_unused_tag = ^job[3:2];

  // Operation select; subtraction wraps in 16-bit two's complement
  always_comb begin
    result = '0;
    case (w_op)
      OP_ADD:  result = {8'h00, w_a} + {8'h00, w_b};
      OP_SUB:  result = {8'h00, w_a} - {8'h00, w_b};
      OP_MUL:  result = {8'h00, w_a} * {8'h00, w_b};
      default: result = '0;
    endcase
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_job_arbiter
// Description : Round-robin arbiter sharing one ALU among NREQ requesters,
//               one registered job stage, and a credit-reserved result FIFO
//               returned over valid/ready.
//               Optional macro ALU_ARB_STATS_EN adds stat_jobs / stat_stall.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_job_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [JOB_W*NREQ-1:0]   req_opcode,
  output logic [NREQ-1:0]         req_ready,
  output logic                    res_valid,
  output logic [RES_W-1:0]        res_data,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [1:0]              res_core,
  input  logic                    res_ready,
`ifdef ALU_ARB_STATS_EN
  output logic                    busy,
  output logic [31:0]             stat_jobs,
  output logic [31:0]             stat_stall
`else
  output logic                    busy
`endif
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_s1_valid;
  logic [JOB_W-1:0]  r_s1_job;
  logic [ID_W-1:0]   r_s1_id;
  res_entry_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_space;
  logic              w_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [NREQ-1:0]   w_grant;
  logic              w_accept;
  logic [JOB_W-1:0]  w_acc_job;
  logic [RES_W-1:0]  w_alu_res;
  logic              w_push;
  logic              w_pop;
  res_entry_t        w_push_entry;
  res_entry_t        w_head;
  logic              w_unused_id;

  // Credit includes the job in stage 1, so the push one cycle later always fits.
  // A same-cycle pop is deliberately not counted as free space.
  assign w_space = ((CNT_W'(r_count) + CNT_W'(r_s1_valid)) < CNT_W'(FIFO_DEPTH)) && !rst;

  // Round-robin search starting at rr_ptr, wrapping through all requesters
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
    if (w_found && w_space) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign req_ready = w_grant;
  assign w_accept  = w_found && w_space;
  assign w_acc_job = req_opcode[JOB_W*int'(w_gnt_idx) +: JOB_W];

  // Arbitration pointer and stage-1 job register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_job   <= '0;
      r_s1_id    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_rr_ptr <= (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_s1_job <= w_acc_job;
        r_s1_id  <= w_gnt_idx;
      end
    end
  end

  alu_core u_alu_core (
    .job    (r_s1_job),
    .result (w_alu_res)
  );

  assign w_push            = r_s1_valid;
  assign w_pop             = res_valid && res_ready;
  assign w_push_entry.id   = ID_MAX_W'(r_s1_id);
  assign w_push_entry.core = r_s1_job[3:2];
  assign w_push_entry.data = w_alu_res;

  // Result storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-2 depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign w_unused_id = ^w_head.id;
  assign res_valid   = (r_count != '0);
  assign res_data    = res_valid ? w_head.data : '0;
  assign res_id      = res_valid ? w_head.id[ID_W-1:0] : '0;
  assign res_core    = res_valid ? w_head.core : '0;
  assign busy        = r_s1_valid || (r_count != '0);

`ifdef ALU_ARB_STATS_EN
  // Saturating activity counters: accepted jobs and cycles stalled for credit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_jobs  <= '0;
      stat_stall <= '0;
    end else begin
      if (w_accept && (stat_jobs != 32'hFFFF_FFFF)) begin
        stat_jobs <= stat_jobs + 32'd1;
      end
      if ((|req_valid) && !w_accept && (stat_stall != 32'hFFFF_FFFF)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule : alu_job_arbiter
`default_nettype wire

// File: tb/tb_alu_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_job_arbiter
// Description : Self-checking bench for alu_job_arbiter (NREQ=4, FIFO_DEPTH=4).
//               Honours ALU_ARB_STATS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_job_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [79:0] req_opcode;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  res_id;
  logic [1:0]  res_core;
  logic        res_ready;
  logic        busy;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_jobs;
  logic [31:0] stat_stall;
`endif

  alu_job_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_opcode (req_opcode),
    .req_ready  (req_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_core   (res_core),
    .res_ready  (res_ready),
`ifdef ALU_ARB_STATS_EN
    .busy       (busy),
    .stat_jobs  (stat_jobs),
    .stat_stall (stat_stall)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [1:0]  core;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          req;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [15:0] exp_data;
    logic [1:0]  exp_core;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  int   stall_cnt = 0;
  exp_t sbq[$];
  int   grant_log[$];
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [19:0] j);
    logic [15:0] a16;
    logic [15:0] b16;
    a16 = {8'h00, j[19:12]};
    b16 = {8'h00, j[11:4]};
    case (j[1:0])
      2'b00:   ref_alu = a16 + b16;
      2'b01:   ref_alu = a16 - b16;
      2'b10:   ref_alu = a16 * b16;
      default: ref_alu = 16'h0000;
    endcase
  endfunction

  function automatic logic [19:0] std_job(input int i);
    logic [1:0] t;
    t = 2'(i);
    std_job = {8'(10 + i), 8'd3, t, 2'b00};
  endfunction

  // One clock: settle inputs, record accepts/pops in the model, then advance
  task automatic cycle();
    exp_t e;
    logic [19:0] j;
    #1;
    if (req_ready != 4'b0000) begin
      chk("grant_onehot", 32'($countones(req_ready)), 32'd1);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        j = req_opcode[20*i +: 20];
        e.id = i; e.core = j[3:2]; e.data = ref_alu(j);
        sbq.push_back(e);
        grant_log.push_back(i);
        acc_cnt++;
      end
    end
    if ((|req_valid) && (req_ready == 4'b0000)) stall_cnt++;
    if (res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_res_id", 32'(res_id), 32'(e.id));
        chk("sb_res_core", 32'(res_core), 32'(e.core));
        chk("sb_res_data", 32'(res_data), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    grant_log.delete();
    acc_cnt = 0;
    stall_cnt = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Vector table: requester, A, B, op, expected result, expected core tag
    vecs[0] = '{2, 8'd200, 8'd100, 4'b0010, 16'd20000, 2'd0};
    vecs[1] = '{0, 8'd3,   8'd5,   4'b0101, 16'hFFFE,  2'd1};
    vecs[2] = '{1, 8'd255, 8'd255, 4'b1000, 16'd510,   2'd2};
    vecs[3] = '{3, 8'd9,   8'd9,   4'b1111, 16'h0000,  2'd3};
    vecs[4] = '{1, 8'd255, 8'd255, 4'b0110, 16'hFE01,  2'd1};
    vecs[5] = '{0, 8'd0,   8'd1,   4'b1001, 16'hFFFF,  2'd2};
    vecs[6] = '{3, 8'd255, 8'd0,   4'b0001, 16'd255,   2'd0};
    vecs[7] = '{2, 8'd7,   8'd6,   4'b1110, 16'd42,    2'd3};

    rst = 1'b1;
    req_valid = '0;
    req_opcode = '0;
    res_ready = 1'b0;
    #2;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_core", 32'(res_core), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    do_reset();

    // Single-job vectors: accept, two edges later the result is at the head
    for (int v = 0; v < 8; v++) begin
      req_opcode = '0;
      req_opcode[20*vecs[v].req +: 20] = {vecs[v].a, vecs[v].b, vecs[v].op};
      req_valid = 4'(1 << vecs[v].req);
      #1;
      chk("vec_grant", 32'(req_ready), 32'(1 << vecs[v].req));
      cycle();
      req_valid = '0;
      chk("vec_busy_s1", 32'(busy), 32'd1);
      chk("vec_not_yet", 32'(res_valid), 32'd0);
      cycle();
      chk("vec_res_valid", 32'(res_valid), 32'd1);
      chk("vec_res_data", 32'(res_data), 32'(vecs[v].exp_data));
      chk("vec_res_id", 32'(res_id), 32'(vecs[v].req));
      chk("vec_res_core", 32'(res_core), 32'(vecs[v].exp_core));
      res_ready = 1'b1;
      cycle();
      res_ready = 1'b0;
      chk("vec_drained", 32'(res_valid), 32'd0);
      chk("vec_idle", 32'(busy), 32'd0);
    end

    // Round robin with full throughput
    do_reset();
    for (int i = 0; i < NREQ; i++) req_opcode[20*i +: 20] = std_job(i);
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
    req_valid = '0;
    for (int k = 0; k < 4; k++) cycle();
    chk("rr_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < grant_log.size() && k < 8; k++) begin
      chk("rr_order", 32'(grant_log[k]), 32'(k % NREQ));
    end
    chk("rr_sb_empty", 32'(sbq.size()), 32'd0);
    chk("rr_idle", 32'(busy), 32'd0);

    // Backpressure: exactly DEPTH accepts, then grants stop
    do_reset();
`ifdef ALU_ARB_STATS_EN
    chk("stat_jobs_rst", stat_jobs, 32'd0);
    chk("stat_stall_rst", stat_stall, 32'd0);
`endif
    req_valid = 4'hF;
    res_ready = 1'b0;
    for (int k = 0; k < 8; k++) cycle();
    chk("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
    chk("bp_no_grant", 32'(req_ready), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_stalls", 32'(stall_cnt), 32'd4);
`ifdef ALU_ARB_STATS_EN
    chk("stat_jobs", stat_jobs, 32'(acc_cnt));
    chk("stat_stall", stat_stall, 32'(stall_cnt));
`endif
    // Drain with requests still pending; pop frees space one cycle later
    res_ready = 1'b1;
    cycle();
    chk("bp_pop_no_credit", 32'(acc_cnt), 32'(DEPTH));
    for (int k = 0; k < 7; k++) cycle();
    chk("bp_resume", 32'(acc_cnt > DEPTH), 32'd1);
    if (grant_log.size() > DEPTH) chk("bp_resume_id", 32'(grant_log[DEPTH]), 32'd0);
    req_valid = '0;
    for (int k = 0; k < 8; k++) cycle();
    chk("bp_sb_empty", 32'(sbq.size()), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);

    // Reset with queued work discards everything
    do_reset();
    req_valid = 4'hF;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    chk("t1_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_res_valid", 32'(res_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_req_ready", 32'(req_ready), 32'd0);
    chk("t1_res_data", 32'(res_data), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("t1_stat_jobs", stat_jobs, 32'd0);
    chk("t1_stat_stall", stat_stall, 32'd0);
`endif
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t1_no_stale", 32'(res_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always ends
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_job_arbiter
`default_nettype wire
